// File: rtl/sm83_oam_dma.sv
// ---------------------------------------------------------------------------
// sm83_oam_dma
//
// OAM DMA controller and bus arbiter sitting beside the sm83 core.
// A write to the DMA register (FF46) starts a XFER_LEN-byte copy from
// {src,00..} into OAM, one byte per M-cycle. While the copy runs the block
// owns the source bus and flags CPU accesses that collide with it, so the
// CPU bus mux can return 0xFF on reads and drop writes.
//
// Ports:
//   clk           clock, all state on posedge
//   reset         synchronous, active-high
//   mcyc          one-clk pulse at T4 of every M-cycle
//   reg_we        one-clk write strobe for the FF46 register
//   reg_din       register write data
//   reg_dout      read-back of the last written register value
//   src_adr       DMA source address ({hi, idx})
//   src_rd        DMA read request on the source bus
//   src_din       source read data, valid when mcyc=1
//   oam_adr       OAM write index (held between writes)
//   oam_dout      OAM write data (held between writes)
//   oam_wr        one-clk OAM write strobe, one clk after the sampling mcyc
//   cpu_adr       current CPU address
//   busy          DMA owns OAM
//   cpu_conflict  CPU access at cpu_adr must be blocked
// ---------------------------------------------------------------------------
module sm83_oam_dma #(
    parameter int WORD_SIZE = 8,
    parameter int ADR_WIDTH = 16,
    parameter int XFER_LEN  = 160
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mcyc,
    input  logic                 reg_we,
    input  logic [WORD_SIZE-1:0] reg_din,
    output logic [WORD_SIZE-1:0] reg_dout,
    output logic [ADR_WIDTH-1:0] src_adr,
    output logic                 src_rd,
    input  logic [WORD_SIZE-1:0] src_din,
    output logic [WORD_SIZE-1:0] oam_adr,
    output logic [WORD_SIZE-1:0] oam_dout,
    output logic                 oam_wr,
    input  logic [ADR_WIDTH-1:0] cpu_adr,
    output logic                 busy,
    output logic                 cpu_conflict
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } state_t;

    // Which physical bus an address lives on; two masters on the same bus
    // collide, OAM itself is always owned by the DMA while busy.
    typedef enum logic [1:0] {
        BUS_VRAM,
        BUS_EXT,
        BUS_OAM,
        BUS_NONE
    } bus_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] reg_q, reg_d;
    logic [7:0]           idx_q, idx_d;
    logic                 restart_q, restart_d;
    logic [WORD_SIZE-1:0] latch_q, latch_d;
    logic [7:0]           wr_idx_q, wr_idx_d;
    logic                 oam_wr_q, oam_wr_d;

    logic [WORD_SIZE-1:0] src_hi;
    bus_t                 cpu_bus;
    bus_t                 src_bus;

    function automatic bus_t bus_class(input logic [ADR_WIDTH-1:0] a);
        bus_t c;
        if (a >= ADR_WIDTH'(16'hFF00))
            c = BUS_NONE;
        else if (a >= ADR_WIDTH'(16'hFE00))
            c = BUS_OAM;
        else if (a >= ADR_WIDTH'(16'h8000) && a <= ADR_WIDTH'(16'h9FFF))
            c = BUS_VRAM;
        else
            c = BUS_EXT;
        return c;
    endfunction

    // Sources E0..FF hit echo RAM, which mirrors C0..DF on the external bus.
    assign src_hi  = (reg_q < WORD_SIZE'(8'hE0)) ? reg_q : reg_q - WORD_SIZE'(8'h20);
    assign src_adr = ADR_WIDTH'({src_hi, idx_q});
    assign src_rd  = (state_q == XFER);

    // A restart keeps OAM locked through the setup M-cycle; a fresh start
    // from IDLE leaves it open until the first byte is fetched.
    assign busy = (state_q == XFER) || (state_q == START && restart_q);

    assign cpu_bus      = bus_class(cpu_adr);
    assign src_bus      = bus_class(src_adr);
    assign cpu_conflict = busy && (cpu_bus == BUS_OAM || cpu_bus == src_bus);

    assign reg_dout = reg_q;
    assign oam_wr   = oam_wr_q;
    assign oam_adr  = WORD_SIZE'(wr_idx_q);
    assign oam_dout = latch_q;

    // Next-state logic. A register write wins over mcyc in the same clk:
    // it neither advances START nor lets an in-flight XFER byte land.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        reg_d     = reg_q;
        idx_d     = idx_q;
        restart_d = restart_q;
        latch_d   = latch_q;
        wr_idx_d  = wr_idx_q;
        oam_wr_d  = 1'b0;

        if (reg_we) begin
            reg_d     = reg_din;
            idx_d     = 8'd0;
            state_d   = START;
            restart_d = (state_q == XFER) || (state_q == START && restart_q);
        end else if (mcyc) begin
            unique case (state_q)
                START: state_d = XFER;
                XFER: begin
                    latch_d  = src_din;
                    wr_idx_d = idx_q;
                    oam_wr_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        restart_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            reg_q     <= '0;
            idx_q     <= 8'd0;
            restart_q <= 1'b0;
            // NOTE: the data latch and write index are reset too, even though
            // they are plain datapath registers, because they drive oam_dout
            // and oam_adr directly and must read as zero out of reset.
            latch_q   <= '0;
            wr_idx_q  <= 8'd0;
            oam_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            idx_q     <= idx_d;
            restart_q <= restart_d;
            latch_q   <= latch_d;
            wr_idx_q  <= wr_idx_d;
            oam_wr_q  <= oam_wr_d;
        end
    end

endmodule

// File: doc/sm83_oam_dma.md
Name: sm83_oam_dma

Overview:
OAM DMA controller and bus arbiter next to the sm83 core. A CPU write to the DMA register (FF46) starts a 160-byte copy from {src,00..9F} into OAM, one byte per M-cycle. While the copy runs, the block drives the source bus and tells the CPU-side bus logic which CPU accesses conflict with it. The CPU bus mux uses cpu_conflict to return 0xFF on reads and suppress writes.

Parameters:
WORD_SIZE, 8, data width
ADR_WIDTH, 16, address width
XFER_LEN, 160, bytes per transfer; must be ≤256

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high
mcyc  input  1  one-clk pulse at the last T-cycle (T4) of each M-cycle
reg_we  input  1  one-clk write strobe for the FF46 register
reg_din  input  WORD_SIZE  write data
reg_dout  output  WORD_SIZE  read-back of the last written value
src_adr  output  ADR_WIDTH  DMA source address
src_rd  output  1  DMA read request on the source bus
src_din  input  WORD_SIZE  source read data, valid when mcyc=1
oam_adr  output  WORD_SIZE  OAM write index
oam_dout  output  WORD_SIZE  OAM write data
oam_wr  output  1  one-clk OAM write strobe
cpu_adr  input  ADR_WIDTH  current CPU address
busy  output  1  DMA owns OAM
cpu_conflict  output  1  CPU access at cpu_adr must be blocked

Behaviour:
- Reset: state=IDLE, reg=0x00, idx=0, restart=0, data latch=0x00. Outputs: busy=0, src_rd=0, oam_wr=0, cpu_conflict=0, oam_adr=0x00, oam_dout=0x00, src_adr=0x0000. Reset overrides reg_we and mcyc in the same clk, including mid-transfer.
- States: IDLE, START, XFER. idx is an 8-bit counter.
- reg_we in any state:
  - reg ← reg_din; idx ← 0; state ← START.
  - restart ← 1 if the state was XFER, or START with restart already set; else 0.
  - reg_we has priority over mcyc in the same clk. That mcyc does not advance START.
  - An in-flight XFER byte at that mcyc is dropped: no oam_wr, no latch.
- START: advances to XFER on the first mcyc in a later clk than the write. This gives one full M-cycle of setup.
- XFER:
  - src_rd=1, src_adr={hi,idx}. hi = reg if reg<0xE0, else reg−0x20 (echo RAM mapping).
  - At mcyc: latch ← src_din; wr_idx ← idx; next clk oam_wr=1, oam_adr=wr_idx, oam_dout=latch. So oam_wr always lands one clk after the mcyc.
  - At the same mcyc: if idx==XFER_LEN−1, state ← IDLE and restart ← 0; else idx ← idx+1.
  - The final oam_wr (index 0x9F) still issues in the clk after the return to IDLE.
- oam_adr and oam_dout hold their last values when oam_wr=0.
- busy = (state==XFER) | (state==START & restart). A restart keeps OAM locked continuously; a fresh start from IDLE gives busy=0 during START.
- Bus classification of an address a:
  - VRAM: 0x8000–0x9FFF.
  - EXT: a<0xFE00 and not VRAM.
  - OAM: 0xFE00–0xFEFF.
  - NONE: ≥0xFF00.
- cpu_conflict = busy & (class(cpu_adr)==OAM | class(cpu_adr)==class(src_adr)).
  - During START with restart, src_adr still uses the new reg value.
  - HRAM and IO (FF00–FFFF) never conflict.
  - cpu_conflict is combinational from cpu_adr and registered state.
- reg_dout = reg at all times. Reads never affect the transfer.
- Throughput: XFER_LEN+1 M-cycles from write to last oam_wr, plus 1 clk.

Test Plan:
- Basic copy: reset, reg_we 0xC1, run mcyc every 4 clks with src_din=low byte of src_adr.
  - busy rises at first mcyc after write.
  - 160 oam_wr pulses, oam_adr 0x00..0x9F, oam_dout 0x00..0x9F, src_adr 0xC100..0xC19F.
  - busy falls at the 160th mcyc; reg_dout=0xC1.
- Echo mapping: reg_we 0xFE → src_adr 0xDE00..0xDE9F. reg_we 0xE0 → 0xC000 start.
- Restart: write 0x80, then after 10 bytes write 0xC0.
  - busy stays 1 with no gap.
  - idx restarts at 0 with src_adr 0xC000.
  - Exactly 160 more oam_wr pulses follow.
  - A reg_we coincident with mcyc produces no oam_wr for that slot.
- Conflicts during a transfer from 0xC0:
  - cpu_adr 0x1234 → 1; 0x8000 → 0; 0xFE10 → 1; 0xFF80 → 0; 0xFF46 → 0.
  - With source 0x80: cpu_adr 0x9FFF → 1; 0xC000 → 0.
  - After completion, all → 0.
- Reset mid-transfer at byte 50:
  - next clk busy=0, src_rd=0, oam_wr=0, reg_dout=0x00.
  - Subsequent mcyc pulses cause no writes.
- Fresh start: reg_we from IDLE with mcyc in the same clk.
  - START persists until the next mcyc, with busy=0 and cpu_conflict=0 during START.
